// File: rtl/ldst_resp_unit_pkg.sv
// Shared definitions for the load/store response unit.
// Size encodings, FSM state enum and the lane helpers (misalign, strobe, extract/extend).
// Pure declarations; no state, no handshakes.
package ldst_resp_unit_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Size 2'b11 is not a legal access width, so it is reported as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return |off;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    return 4'b0001 << off;
      SZ_H:    return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then sign- or zero-extend it.
  function automatic logic [31:0] lane_extend(input logic [31:0] rdata, input logic [1:0] off,
                                              input logic [1:0] size, input logic sext);
    logic [31:0] sh;
    logic [31:0] res;
    sh = rdata >> {off, 3'b000};
    case (size)
      SZ_B:    res = {{24{sext & sh[7]}}, sh[7:0]};
      SZ_H:    res = {{16{sext & sh[15]}}, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ldst_req_fifo.sv
// Synchronous request FIFO with full/empty flags; head is visible combinationally.
// Latency: an entry pushed on one edge is at the head from the next cycle.
// Backpressure: pushes while full and pops while empty are ignored.
module ldst_req_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_push_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_head_dat,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full     = (r_count == CW'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign w_do_push  = i_push && !o_full;
  assign w_do_pop   = i_pop && !o_empty;
  assign o_head_dat = r_mem[r_rd_ptr];

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ldst_resp_unit.sv
// Queues LD/ST requests, issues them one at a time to memory, returns tagged completions.
// Latency: store/misaligned 3 cycles accept-to-resp_valid; load 3 + memory latency.
// Backpressure: req_ready drops when the queue is full; resp payload holds until resp_ready.
module ldst_resp_unit import ldst_resp_unit_pkg::*; #(
  parameter int XLEN   = 32,
  parameter int TAG_W  = 6,
  parameter int QDEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_is_store,
  input  logic [1:0]       req_size,
  input  logic             req_sext,
  input  logic [XLEN-1:0]  req_addr,
  input  logic [XLEN-1:0]  req_data,
  input  logic [TAG_W-1:0] req_tag,
  output logic             mem_req_valid,
  output logic             mem_we,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic             mem_rvalid,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [TAG_W-1:0] resp_tag,
  output logic [XLEN-1:0]  resp_data,
  output logic             resp_is_store,
  output logic             resp_misalign
);

  localparam int FW = 4 + 2 * XLEN + TAG_W;

  logic [FW-1:0]    w_push_dat;
  logic [FW-1:0]    w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_h_store;
  logic [1:0]       w_h_size;
  logic             w_h_sext;
  logic [XLEN-1:0]  w_h_addr;
  logic [XLEN-1:0]  w_h_data;
  logic [TAG_W-1:0] w_h_tag;
  logic             w_h_mis;
  logic [XLEN-1:0]  w_st_wdata;

  state_t           r_state;
  logic             r_is_store;
  logic [1:0]       r_size;
  logic             r_sext;
  logic [1:0]       r_off;
  logic [TAG_W-1:0] r_tag;
  logic             r_mis;
  logic             r_mem_req_valid;
  logic             r_mem_we;
  logic [XLEN-1:0]  r_mem_addr;
  logic [XLEN-1:0]  r_mem_wdata;
  logic [3:0]       r_mem_wstrb;
  logic             r_resp_valid;
  logic [XLEN-1:0]  r_resp_data;
  logic [TAG_W-1:0] r_resp_tag;
  logic             r_resp_is_store;
  logic             r_resp_misalign;

  assign req_ready  = !w_full && !rst;
  assign w_push     = req_valid && req_ready;
  assign w_pop      = (r_state == ST_IDLE) && !w_empty;
  assign w_push_dat = {req_is_store, req_size, req_sext, req_addr, req_data, req_tag};
  assign {w_h_store, w_h_size, w_h_sext, w_h_addr, w_h_data, w_h_tag} = w_head;
  assign w_h_mis    = is_misaligned(w_h_size, w_h_addr[1:0]);

  // Replicate store data across every lane; the strobe selects the live ones.
  always_comb begin
    w_st_wdata = w_h_data;
    case (w_h_size)
      SZ_B:    w_st_wdata = XLEN'({4{w_h_data[7:0]}});
      SZ_H:    w_st_wdata = XLEN'({2{w_h_data[15:0]}});
      default: w_st_wdata = w_h_data;
    endcase
  end

  ldst_req_fifo #(.W(FW), .DEPTH(QDEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // Single in-flight FSM; memory request fields are loaded on pop so they are live in ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_is_store      <= 1'b0;
      r_size          <= SZ_B;
      r_sext          <= 1'b0;
      r_off           <= 2'b00;
      r_tag           <= '0;
      r_mis           <= 1'b0;
      r_mem_req_valid <= 1'b0;
      r_mem_we        <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_wdata     <= '0;
      r_mem_wstrb     <= 4'b0000;
      r_resp_valid    <= 1'b0;
      r_resp_data     <= '0;
      r_resp_tag      <= '0;
      r_resp_is_store <= 1'b0;
      r_resp_misalign <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_is_store      <= w_h_store;
            r_size          <= w_h_size;
            r_sext          <= w_h_sext;
            r_off           <= w_h_addr[1:0];
            r_tag           <= w_h_tag;
            r_mis           <= w_h_mis;
            r_mem_req_valid <= !w_h_mis;
            r_mem_we        <= w_h_store && !w_h_mis;
            r_mem_addr      <= {w_h_addr[XLEN-1:2], 2'b00};
            r_mem_wdata     <= w_st_wdata;
            r_mem_wstrb     <= (w_h_store && !w_h_mis) ? store_strb(w_h_size, w_h_addr[1:0]) : 4'b0000;
            r_state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_mem_req_valid <= 1'b0;
          r_mem_we        <= 1'b0;
          r_mem_wstrb     <= 4'b0000;
          if (r_mis || r_is_store) begin
            r_resp_valid    <= 1'b1;
            r_resp_tag      <= r_tag;
            r_resp_is_store <= r_is_store;
            r_resp_misalign <= r_mis;
            r_resp_data     <= '0;
            r_state         <= ST_RESP;
          end else begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            r_resp_valid    <= 1'b1;
            r_resp_tag      <= r_tag;
            r_resp_is_store <= 1'b0;
            r_resp_misalign <= 1'b0;
            r_resp_data     <= XLEN'(lane_extend(mem_rdata[31:0], r_off, r_size, r_sext));
            r_state         <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_req_valid = r_mem_req_valid;
  assign mem_we        = r_mem_we;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  assign mem_wstrb     = r_mem_wstrb;
  assign resp_valid    = r_resp_valid;
  assign resp_data     = r_resp_data;
  assign resp_tag      = r_resp_tag;
  assign resp_is_store = r_resp_is_store;
  assign resp_misalign = r_resp_misalign;

endmodule

// File: tb/tb_ldst_resp_unit.sv
// Bench for ldst_resp_unit: directed corner cases plus randomized traffic.
// Expected completions come from an in-order transaction model and a simple memory model.
// Latency, ordering, queue-full and reset behaviour are checked explicitly.
module tb_ldst_resp_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [1:0]  req_size;
  logic        req_sext;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [5:0]  req_tag;
  logic        mem_req_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [5:0]  resp_tag;
  logic [31:0] resp_data;
  logic        resp_is_store;
  logic        resp_misalign;

  ldst_resp_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_size(req_size), .req_sext(req_sext),
    .req_addr(req_addr), .req_data(req_data), .req_tag(req_tag),
    .mem_req_valid(mem_req_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_tag(resp_tag),
    .resp_data(resp_data), .resp_is_store(resp_is_store), .resp_misalign(resp_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_store;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] data;
    logic [5:0]  tag;
    int          acc_cyc;
    bit          seen;
  } txn_t;

  txn_t stim[$];
  txn_t pend[$];
  logic [5:0] resp_tags[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int vld_pct = 100;
  int rr_mode = 0;
  int lat_min = 1;
  int lat_max = 1;
  bit rv_sched = 0;
  int rv_cyc = 0;
  bit have_rdata = 0;
  logic [31:0] exp_rdata = '0;
  bit force_en = 0;
  logic [31:0] force_val = '0;
  int memreq_txn = 0;
  int memreq_total = 0;
  int accepted = 0;
  int last_lat = 0;
  logic [31:0] last_mem_addr = '0;
  logic [31:0] last_mem_wdata = '0;
  logic [3:0]  last_mem_wstrb = '0;
  logic [31:0] last_resp_data = '0;
  logic [5:0]  last_resp_tag = '0;
  logic        last_resp_is_store = 1'b0;
  logic        last_resp_misalign = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] s);
    case (s)
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit misal(input txn_t t);
    int nb;
    nb = nbytes(t.size);
    if (nb == 0) return 1'b1;
    return (int'(t.addr[1:0]) % nb) != 0;
  endfunction

  function automatic logic [3:0] exp_strb(input txn_t t);
    logic [3:0] s;
    int off;
    int nb;
    s = 4'b0000;
    off = int'(t.addr[1:0]);
    nb = nbytes(t.size);
    for (int i = 0; i < 4; i++)
      if (i >= off && i < off + nb) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] exp_wdata(input txn_t t);
    logic [31:0] w;
    int nb;
    nb = nbytes(t.size);
    if (nb == 0) nb = 4;
    w = '0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = t.data[8*(i % nb) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] exp_load(input txn_t t, input logic [31:0] rd);
    longint v;
    longint span;
    int nb;
    int off;
    nb = nbytes(t.size);
    off = int'(t.addr[1:0]);
    span = longint'(1) << (8 * nb);
    v = longint'(rd >> (8 * off)) % span;
    if (t.sext && nb < 4 && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  // ---------------- one clock cycle of observation + driving ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step();
    txn_t t;
    logic [31:0] exp_d;
    if (mem_req_valid) begin
      memreq_total++;
      memreq_txn++;
      if (pend.size() == 0) chk("memreq_spurious", 32'(1), 32'(0));
      else begin
        t = pend[0];
        chk("memreq_once", 32'(memreq_txn), 32'(1));
        chk("memreq_for_misaligned", 32'(misal(t)), 32'(0));
        chk("mem_we", 32'(mem_we), 32'(t.is_store));
        chk("mem_addr", mem_addr, t.addr & ~32'h3);
        chk("mem_wstrb", 32'(mem_wstrb), t.is_store ? 32'(exp_strb(t)) : 32'(0));
        if (t.is_store) chk("mem_wdata", mem_wdata, exp_wdata(t));
        last_mem_addr  = mem_addr;
        last_mem_wdata = mem_wdata;
        last_mem_wstrb = mem_wstrb;
        if (!t.is_store && lat_max > 0) begin
          rv_sched = 1;
          rv_cyc = cyc + int'($urandom_range(lat_max, lat_min));
        end
      end
    end
    if (resp_valid) begin
      if (pend.size() == 0) chk("resp_spurious", 32'(1), 32'(0));
      else begin
        t = pend[0];
        if (!pend[0].seen) begin
          pend[0].seen = 1;
          last_lat = cyc - t.acc_cyc;
        end
        chk("resp_tag", 32'(resp_tag), 32'(t.tag));
        chk("resp_is_store", 32'(resp_is_store), 32'(t.is_store));
        chk("resp_misalign", 32'(resp_misalign), 32'(misal(t)));
        if (misal(t) || t.is_store) exp_d = '0;
        else begin
          if (!have_rdata) chk("resp_before_rdata", 32'(1), 32'(0));
          exp_d = exp_load(t, exp_rdata);
        end
        chk("resp_data", resp_data, exp_d);
      end
    end
    // drive inputs for the coming edge
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom();
    if (rv_sched && cyc == rv_cyc) begin
      mem_rvalid = 1'b1;
      if (force_en) mem_rdata = force_val;
      exp_rdata  = mem_rdata;
      have_rdata = 1;
      rv_sched   = 0;
    end
    if (stim.size() > 0 && int'($urandom_range(99)) < vld_pct) begin
      req_valid    = 1'b1;
      req_is_store = stim[0].is_store;
      req_size     = stim[0].size;
      req_sext     = stim[0].sext;
      req_addr     = stim[0].addr;
      req_data     = stim[0].data;
      req_tag      = stim[0].tag;
    end else begin
      req_valid    = 1'b0;
      req_is_store = 1'($urandom_range(1));
      req_size     = 2'($urandom_range(3));
      req_sext     = 1'($urandom_range(1));
      req_addr     = $urandom();
      req_data     = $urandom();
      req_tag      = 6'($urandom_range(63));
    end
    case (rr_mode)
      0:       resp_ready = 1'b1;
      1:       resp_ready = 1'($urandom_range(1));
      default: resp_ready = 1'b0;
    endcase
    // handshakes that the coming edge completes
    if (req_valid && req_ready) begin
      t = stim.pop_front();
      t.acc_cyc = cyc;
      t.seen = 0;
      pend.push_back(t);
      accepted++;
    end
    if (resp_valid && resp_ready && pend.size() > 0) begin
      void'(pend.pop_front());
      resp_tags.push_back(resp_tag);
      last_resp_data     = resp_data;
      last_resp_tag      = resp_tag;
      last_resp_is_store = resp_is_store;
      last_resp_misalign = resp_misalign;
      memreq_txn = 0;
      have_rdata = 0;
    end
    tick();
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while ((stim.size() > 0 || pend.size() > 0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) chk("drain_timeout", 32'(stim.size() + pend.size()), 32'(0));
  endtask

  task automatic add(input logic st, input logic [1:0] sz, input logic sx,
                     input logic [31:0] a, input logic [31:0] d, input logic [5:0] tg);
    txn_t t;
    t.is_store = st; t.size = sz; t.sext = sx; t.addr = a; t.data = d; t.tag = tg;
    t.acc_cyc = 0; t.seen = 0;
    stim.push_back(t);
  endtask

  task automatic add_rand();
    logic [31:0] a;
    a = $urandom();
    if ($urandom_range(1) == 1) a[1:0] = 2'b00;
    add(1'($urandom_range(1)), 2'($urandom_range(3)), 1'($urandom_range(1)),
        a, $urandom(), 6'($urandom_range(63)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
    $fatal(1);
  end

  initial begin
    int mr0;
    int acc0;
    int base;
    rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_size = 2'b00; req_sext = 1'b0;
    req_addr = '0; req_data = '0; req_tag = '0; mem_rvalid = 1'b0; mem_rdata = '0;
    resp_ready = 1'b0;
    tick();
    tick();
    // reset state
    chk("rst_req_ready_low", 32'(req_ready), 32'(0));
    chk("rst_resp_valid", 32'(resp_valid), 32'(0));
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'(0));
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'(0));
    chk("rst_resp_data", resp_data, 32'(0));
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", 32'(req_ready), 32'(1));

    // load byte, sign extended, from top lane
    force_en = 1; force_val = 32'h80FF_FF12; lat_min = 1; lat_max = 1;
    add(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 6'h2A);
    run_until_idle(60);
    chk("lb_sext_data", last_resp_data, 32'hFFFF_FF80);
    chk("lb_tag", 32'(last_resp_tag), 32'h2A);
    chk("lb_wstrb", 32'(last_mem_wstrb), 32'(0));
    chk("lb_latency", 32'(last_lat), 32'(4));

    // load half, upper lane, zero then sign extended; memory latency 3
    force_val = 32'h9ABC_1234; lat_min = 3; lat_max = 3;
    add(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 6'h11);
    run_until_idle(60);
    chk("lh_zext_data", last_resp_data, 32'h0000_9ABC);
    chk("lh_latency", 32'(last_lat), 32'(6));
    add(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 6'h12);
    run_until_idle(60);
    chk("lh_sext_data", last_resp_data, 32'hFFFF_9ABC);
    force_en = 0;

    // byte store into lane 1
    mr0 = memreq_total;
    add(1'b1, 2'b00, 1'b0, 32'h201, 32'h0000_0055, 6'h05);
    run_until_idle(60);
    chk("sb_memreq_count", 32'(memreq_total - mr0), 32'(1));
    chk("sb_mem_addr", last_mem_addr, 32'h200);
    chk("sb_wstrb", 32'(last_mem_wstrb), 32'b0010);
    chk("sb_wdata_lane1", 32'(last_mem_wdata[15:8]), 32'h55);
    chk("sb_resp_is_store", 32'(last_resp_is_store), 32'(1));
    chk("sb_latency", 32'(last_lat), 32'(3));

    // misaligned word load never reaches memory
    mr0 = memreq_total;
    add(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 6'h07);
    run_until_idle(60);
    chk("lw_mis_memreq_count", 32'(memreq_total - mr0), 32'(0));
    chk("lw_mis_flag", 32'(last_resp_misalign), 32'(1));
    chk("lw_mis_data", last_resp_data, 32'(0));

    // queue fill: 4 queued + 1 in flight, sixth request must be refused
    rr_mode = 2; lat_min = 1; lat_max = 2;
    acc0 = accepted;
    base = resp_tags.size();
    for (int i = 0; i < 6; i++) add(1'b1, 2'b10, 1'b0, 32'h300 + 32'(4 * i), $urandom(), 6'(i));
    for (int i = 0; i < 14; i++) step();
    chk("full_accepted", 32'(accepted - acc0), 32'(5));
    chk("full_req_ready", 32'(req_ready), 32'(0));
    rr_mode = 0;
    run_until_idle(100);
    chk("full_resp_count", 32'(resp_tags.size() - base), 32'(6));
    for (int i = 0; i < 6; i++)
      if (base + i < resp_tags.size()) chk("order_tag", 32'(resp_tags[base + i]), 32'(i));

    // reset while a load waits for memory, with one more request queued behind it
    lat_max = 0;
    mr0 = memreq_total;
    add(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 6'h20);
    for (int i = 0; i < 20 && memreq_total == mr0; i++) step();
    chk("rst_test_memreq_seen", 32'(memreq_total - mr0), 32'(1));
    add(1'b1, 2'b10, 1'b0, 32'h404, 32'hDEAD_BEEF, 6'h21);
    step();
    step();
    rst = 1'b1; req_valid = 1'b0; mem_rvalid = 1'b0; resp_ready = 1'b1;
    #1;
    chk("mid_rst_req_ready", 32'(req_ready), 32'(0));
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_resp_valid", 32'(resp_valid), 32'(0));
    chk("mid_rst_resp_tag", 32'(resp_tag), 32'(0));
    chk("mid_rst_resp_is_store", 32'(resp_is_store), 32'(0));
    chk("mid_rst_resp_misalign", 32'(resp_misalign), 32'(0));
    chk("mid_rst_mem_we", 32'(mem_we), 32'(0));
    chk("mid_rst_req_ready", 32'(req_ready), 32'(1));
    stim.delete(); pend.delete(); rv_sched = 0; have_rdata = 0; memreq_txn = 0;
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_rvalid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("late_rvalid_resp_valid", 32'(resp_valid), 32'(0));
      chk("late_rvalid_mem_req", 32'(mem_req_valid), 32'(0));
      tick();
    end

    // randomized traffic, random gaps and backpressure
    vld_pct = 60; rr_mode = 1; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 200; i++) add_rand();
    run_until_idle(6000);
    // randomized back-to-back traffic
    vld_pct = 100; rr_mode = 0; lat_min = 1; lat_max = 1;
    for (int i = 0; i < 100; i++) add_rand();
    run_until_idle(3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
